// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART types, baud-select codes and default sizes  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// +--------------------------------------------------------------------+
// | uart_rx_sync : rx_serial synchroniser plus falling-edge detector   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic rx_serial,
  output logic rxs,
  output logic rxs_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rxs_q;
  logic                   rxs_d;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_comb sync_d = rx_serial;
    end else begin : g_chain
      always_comb sync_d = {sync_q[SYNC_STAGES-2:0], rx_serial};
    end
  endgenerate

  always_comb rxs_d = sync_q[SYNC_STAGES-1];

  // Reset to the idle-high level so release never looks like a start edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      rxs_q  <= rxs_d;
    end
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign rxs_fall = rxs_q & ~rxs;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// +--------------------------------------------------------------------+
// | uart_rx_ctrl : UART receive sequencer, valid/ack byte output;      |
// | parity checking is enabled by defining UART_RX_PARITY_EN. Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [SCW-1:0] HALF_M1  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] FULL_M1  = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 baud_in_q, baud_in_d;
  logic [SCW-1:0]       samp_q, samp_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 tick;
  logic                 rxs;
  logic                 rxs_fall;
  logic                 drop;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rxs       (rxs),
    .rxs_fall  (rxs_fall)
  );

  assign tick = baud_in & ~baud_in_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign drop       = par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign drop       = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    baud_in_d     = baud_in;
    samp_d        = samp_q;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    valid_d       = valid_q & ~rx_ack;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rxs_fall) begin
          samp_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == HALF_M1) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              samp_d  = '0;
              bit_d   = '0;
              state_d = DATA;
`ifdef UART_RX_PARITY_EN
              par_bad_d = 1'b0;
`endif
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_q == FULL_M1) begin
            samp_d  = '0;
            shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (samp_q == FULL_M1) begin
            samp_d       = '0;
            par_bad_d    = ^{shreg_q, rxs};
            parity_err_d = ^{shreg_q, rxs};
            state_d      = STOP;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (samp_q == FULL_M1) begin
            samp_d  = '0;
            state_d = IDLE;
            // An ack in this same clock frees the holding register for the new byte.
            if (!rxs) begin
              frame_err_d = 1'b1;
            end else if (!drop) begin
              if (!valid_q || rx_ack) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
              end else begin
                overrun_err_d = 1'b1;
              end
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      baud_in_q     <= 1'b0;
      samp_q        <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      baud_in_q     <= baud_in_d;
      samp_q        <= samp_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_uart_rx_ctrl : directed frame vectors for uart_rx_ctrl          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_ctrl;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       baud_in = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int total = 0;
  int passed = 0;
  int ferr_cnt = 0;
  int oerr_cnt = 0;
  int perr_cnt = 0;

  uart_rx_ctrl #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .baud_in     (baud_in),
    .rx_serial   (rx_serial),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clock = ~clock;

  // Pulse-width counters: a pulse wider than one clock counts more than once.
  always @(negedge clock) begin
    if (frame_err)   ferr_cnt++;
    if (overrun_err) oerr_cnt++;
    if (parity_err)  perr_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // One oversample tick: baud_in high for one clock, low for one clock.
  task automatic tk(input int n);
    for (int k = 0; k < n; k++) begin
      baud_in = 1'b1;
      @(posedge clock); @(negedge clock);
      baud_in = 1'b0;
      @(posedge clock); @(negedge clock);
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(posedge clock); @(negedge clock);
    rx_ack = 1'b0;
  endtask

  // The stop bit is sampled on its 10th tick (sync delay + mid-bit alignment).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input logic ack_at_stop, input logic lat_chk);
    rx_serial = 1'b0;
    tk(16);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      tk(16);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = par;
    tk(16);
`endif
    rx_serial = stop;
    tk(9);
    baud_in = 1'b1;
    rx_ack  = ack_at_stop;
    if (lat_chk) check("latency_pre_valid", {31'd0, rx_valid}, 32'd0);
    @(posedge clock); #1;
    if (lat_chk) begin
      check("latency_post_valid", {31'd0, rx_valid}, 32'd1);
      check("latency_post_data", {24'd0, rx_data}, {24'd0, d});
    end
    @(negedge clock);
    baud_in = 1'b0;
    rx_ack  = 1'b0;
    @(posedge clock); @(negedge clock);
    tk(6);
    rx_serial = 1'b1;
    tk(2);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [1:0] mode;       // 0 none, 1 ack before frame, 2 ack in stop-sample clock
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_oerr;
  } vec_t;

  vec_t vecs [9];
  vec_t v;
  logic m_valid;
  int   f0, o0, p0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 2'd0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 2'd1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h22, 1'b1, 2'd2, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 2'd1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h5A, 1'b1, 2'd2, 8'h5A, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clock);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun_err", {31'd0, overrun_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    rst = 1'b1;
    tk(2);

    m_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      if (v.mode == 2'd1) begin
        do_ack();
        m_valid = 1'b0;
      end
      f0 = ferr_cnt;
      o0 = oerr_cnt;
      send_frame(v.d, v.stop, ^v.d, v.mode == 2'd2, !m_valid && v.stop);
      check($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, v.exp_data});
      check($sformatf("vec%0d_rx_valid", i), {31'd0, rx_valid}, {31'd0, v.exp_valid});
      check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, {31'd0, v.exp_ferr});
      check($sformatf("vec%0d_overrun_err", i), oerr_cnt - o0, {31'd0, v.exp_oerr});
      m_valid = v.exp_valid;
    end

    // Short low glitch: start qualification rejects it without side effects.
    f0 = ferr_cnt;
    o0 = oerr_cnt;
    rx_serial = 1'b0;
    tk(5);
    check("glitch_busy_in_start", {31'd0, busy}, 32'd1);
    rx_serial = 1'b1;
    tk(8);
    check("glitch_back_to_idle", {31'd0, busy}, 32'd0);
    check("glitch_rx_data", {24'd0, rx_data}, 32'h5A);
    check("glitch_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("glitch_no_errors", (ferr_cnt - f0) + (oerr_cnt - o0), 32'd0);

    // Reset in the middle of the data bits of 0xFF.
    rx_serial = 1'b0;
    tk(16);
    rx_serial = 1'b1;
    tk(40);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    @(negedge clock);
    tk(2);
    rst = 1'b1;
    tk(2);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_reset_rx_data", {24'd0, rx_data}, 32'h0F);
    check("post_reset_rx_valid", {31'd0, rx_valid}, 32'd1);

`ifdef UART_RX_PARITY_EN
    do_ack();
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    check("parity_bad_pulse", perr_cnt - p0, 32'd1);
    check("parity_bad_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("parity_bad_rx_data", {24'd0, rx_data}, 32'h0F);
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    check("parity_good_no_pulse", perr_cnt - p0, 32'd0);
    check("parity_good_rx_data", {24'd0, rx_data}, 32'h07);
    check("parity_good_rx_valid", {31'd0, rx_valid}, 32'd1);
`else
    p0 = 0;
    check("parity_err_never", perr_cnt - p0, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
